// File: rtl/arb_pkg.sv
// Shared widths, state encoding and helpers for the 8-way round-robin request arbiter.
package arb_pkg;

    localparam int NREQ  = 8;
    localparam int ID_W  = 3;
    localparam int CNT_W = 8;

    localparam logic [ID_W-1:0] PTR_RST = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [NREQ-1:0] onehot(input logic [ID_W-1:0] idx);
        onehot = NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/req_arbiter_prio_enc8.sv
// Combinational 8-to-3 priority encoder; the lowest set index wins.
module prio_enc8
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] vec,
    output logic [ID_W-1:0] idx,
    output logic            Any
);

    always_comb begin
        idx = '0;
        Any = |vec;
        // Scan downward so the last hit, the lowest set bit, is what remains.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/req_arbiter.sv
// Round-robin arbiter for 8 requesters: grants one owner and holds it until
// release or timeout, then moves priority past that owner.
module req_arbiter
    import arb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            EN,
    input  logic [NREQ-1:0] Req,
    input  logic            Rel,
    output logic [NREQ-1:0] Gnt,
    output logic [ID_W-1:0] Id,
    output logic            Busy,
    output logic            Done,
    output logic            Tmo
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        state;
    logic [ID_W-1:0]   ptr;
    logic [CNT_W-1:0]  cnt;

    logic [ID_W-1:0]   shift;
    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [ID_W-1:0]   enc_idx;
    logic              enc_any;
    logic [ID_W-1:0]   winner;

    // Rotate so the slot just past the last owner lands at bit 0; the 3-bit
    // add wraps, so ptr=7 means no rotation at all.
    assign shift   = ptr + 3'd1;
    assign req_dbl = {Req, Req} >> shift;
    assign req_rot = req_dbl[NREQ-1:0];
    assign winner  = enc_idx + shift;

    prio_enc8 u_enc (
        .vec (req_rot),
        .idx (enc_idx),
        .Any (enc_any)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            ptr   <= PTR_RST;
            cnt   <= '0;
            Gnt   <= '0;
            Id    <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            Tmo   <= 1'b0;
        end else begin
            Done <= 1'b0;
            Tmo  <= 1'b0;
            case (state)
                IDLE: begin
                    if (EN && enc_any) begin
                        Gnt   <= onehot(winner);
                        Id    <= winner;
                        Busy  <= 1'b1;
                        cnt   <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    // A release wins over a coincident timeout, so Tmo stays low then.
                    if (Rel || (cnt == CNT_LAST)) begin
                        ptr   <= Id;
                        Gnt   <= '0;
                        Id    <= '0;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        Tmo   <= ~Rel;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_req_arbiter.sv
// Directed self-checking bench for req_arbiter with TIMEOUT=16.
module tb_req_arbiter;

    logic       CLK;
    logic       RST_N;
    logic       EN;
    logic [7:0] Req;
    logic       Rel;
    logic [7:0] Gnt;
    logic [2:0] Id;
    logic       Busy;
    logic       Done;
    logic       Tmo;

    int nvec;
    int nerr;

    req_arbiter #(.TIMEOUT(16)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .EN    (EN),
        .Req   (Req),
        .Rel   (Rel),
        .Gnt   (Gnt),
        .Id    (Id),
        .Busy  (Busy),
        .Done  (Done),
        .Tmo   (Tmo)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        nvec  = 0;
        nerr  = 0;
        RST_N = 1'b0;
        EN    = 1'b0;
        Req   = 8'h00;
        Rel   = 1'b0;

        // Reset state
        #12;
        chk("rst_gnt", Gnt, 8'h00);
        chk("rst_id", Id, 3'd0);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_done", Done, 1'b0);
        chk("rst_tmo", Tmo, 1'b0);
        RST_N = 1'b1;

        // Rotation order: 2 first, then 4
        EN  = 1'b1;
        Req = 8'b0001_0100;
        step();
        chk("rot_gnt0", Gnt, 8'h04);
        chk("rot_id0", Id, 3'd2);
        chk("rot_busy0", Busy, 1'b1);
        Rel = 1'b1;
        step();
        chk("rot_rel_gnt", Gnt, 8'h00);
        chk("rot_rel_done", Done, 1'b1);
        chk("rot_rel_tmo", Tmo, 1'b0);
        chk("rot_rel_busy", Busy, 1'b0);
        Rel = 1'b0;
        step();
        chk("rot_gnt1", Gnt, 8'h10);
        chk("rot_id1", Id, 3'd4);
        chk("rot_done_clr", Done, 1'b0);
        Rel = 1'b1;
        step();
        Rel = 1'b0;
        Req = 8'h00;
        step();
        chk("rot_idle", Busy, 1'b0);

        // Reset mid-grant: search from 5 wraps back to 2
        Req = 8'h04;
        step();
        chk("mid_gnt", Gnt, 8'h04);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_gnt", Gnt, 8'h00);
        chk("async_id", Id, 3'd0);
        chk("async_busy", Busy, 1'b0);
        Req   = 8'hFF;
        RST_N = 1'b1;

        // Full fairness from a fresh pointer
        step();
        for (int i = 0; i < 9; i++) begin
            chk("fair_id", Id, i % 8);
            chk("fair_gnt", Gnt, 8'h01 << (i % 8));
            Rel = 1'b1;
            step();
            chk("fair_gap_busy", Busy, 1'b0);
            chk("fair_gap_done", Done, 1'b1);
            Rel = 1'b0;
            if (i == 8) Req = 8'h00;
            step();
        end
        chk("fair_end_idle", Busy, 1'b0);

        // Timeout: 16 grant cycles, then Done/Tmo, then re-grant of sole requester
        Req = 8'h80;
        step();
        chk("tmo_gnt_first", Gnt, 8'h80);
        chk("tmo_id", Id, 3'd7);
        for (int c = 1; c < 16; c++) begin
            step();
            chk("tmo_hold", Gnt, 8'h80);
            chk("tmo_hold_done", Done, 1'b0);
        end
        step();
        chk("tmo_gnt_off", Gnt, 8'h00);
        chk("tmo_done", Done, 1'b1);
        chk("tmo_tmo", Tmo, 1'b1);
        step();
        chk("tmo_regrant_id", Id, 3'd7);
        chk("tmo_regrant_gnt", Gnt, 8'h80);
        chk("tmo_done_clr", Done, 1'b0);
        chk("tmo_tmo_clr", Tmo, 1'b0);

        // Release in the 16th grant cycle counts as a release
        for (int c = 1; c < 16; c++) begin
            step();
        end
        chk("relt_still_gnt", Gnt, 8'h80);
        Rel = 1'b1;
        step();
        chk("relt_done", Done, 1'b1);
        chk("relt_tmo", Tmo, 1'b0);
        Rel = 1'b0;
        Req = 8'h00;
        step();

        // Enable gating
        EN  = 1'b0;
        Req = 8'h01;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("en_off_gnt", Gnt, 8'h00);
        end
        EN = 1'b1;
        step();
        chk("en_on_gnt", Gnt, 8'h01);
        chk("en_on_id", Id, 3'd0);
        EN  = 1'b0;
        Req = 8'h00;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("en_drop_hold", Gnt, 8'h01);
        end
        Rel = 1'b1;
        step();
        chk("en_rel_done", Done, 1'b1);
        chk("en_rel_gnt", Gnt, 8'h00);

        // Rel held in IDLE does nothing
        step();
        chk("idle_rel_done", Done, 1'b0);
        chk("idle_rel_busy", Busy, 1'b0);
        Rel = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
